// File: rtl/button_debounce_pulse.sv
// Pushbutton debouncer: 2-flop synchronizer feeding a four-state qualify FSM
// that emits a registered debounced level plus one-cycle press/release pulses.
module button_debounce_pulse #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          btn_sync;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          level_n, press_n, release_n;

  // btn_in is asynchronous; only btn_sync may reach the FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1       <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      s1       <= btn_in;
      btn_sync <= s1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      btn_level     <= level_n;
      press_pulse   <= press_n;
      release_pulse <= release_n;
    end
  end

  // cnt counts samples already seen at the new level; the wait state is
  // entered on the first one, so acceptance happens when cnt == CNT_LAST.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    level_n   = btn_level;
    press_n   = 1'b0;
    release_n = 1'b0;
    case (state)
      IDLE: begin
        if (btn_sync) begin
          state_n = PRESS_WAIT;
          cnt_n   = CNT_ONE;
        end else begin
          cnt_n = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = PRESSED;
          cnt_n   = '0;
          level_n = 1'b1;
          press_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!btn_sync) begin
          state_n = RELEASE_WAIT;
          cnt_n   = CNT_ONE;
        end else begin
          cnt_n = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_sync) begin
          state_n = PRESSED;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n   = IDLE;
          cnt_n     = '0;
          level_n   = 1'b0;
          release_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_button_debounce_pulse.sv
// Bench for button_debounce_pulse: run-length reference model checked every
// cycle, directed scenarios with literal expectations, then random bounces.
module tb_button_debounce_pulse;

  localparam int DEB = 4;

  logic       clk;
  logic       reset;
  logic       btn_in;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic [1:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  button_debounce_pulse #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Accepted level flips once DEB consecutive synchronized samples differ
  // from it; the synchronizer is a two-sample delay line.
  bit sq[$] = '{1'b0, 1'b0};
  int m_run = 0;
  bit m_level = 1'b0;
  bit m_press = 1'b0;
  bit m_release = 1'b0;

  always @(posedge clk) begin
    bit s;
    if (!reset) begin
      sq = '{1'b0, 1'b0};
      m_run = 0;
      m_level = 1'b0;
      m_press = 1'b0;
      m_release = 1'b0;
    end else begin
      s = sq.pop_front();
      sq.push_back(btn_in);
      m_press = 1'b0;
      m_release = 1'b0;
      if (s != m_level) m_run++;
      else m_run = 0;
      if (m_run == DEB) begin
        m_level = ~m_level;
        m_run = 0;
        if (m_level) m_press = 1'b1;
        else m_release = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int press_seen = 0;
  int release_seen = 0;

  always @(negedge clk) begin
    if (press_pulse) press_seen++;
    if (release_pulse) release_seen++;
    if (!reset) begin
      check("rst_level", int'(btn_level), 0);
      check("rst_press", int'(press_pulse), 0);
      check("rst_release", int'(release_pulse), 0);
    end else begin
      check("level", int'(btn_level), int'(m_level));
      check("press", int'(press_pulse), int'(m_press));
      check("release", int'(release_pulse), int'(m_release));
    end
    check("pulse_overlap", int'(press_pulse & release_pulse), 0);
  end

  // Downstream 2-bit counter enabled by press_pulse.
  logic [1:0] evt_cnt;
  always @(posedge clk or negedge reset) begin
    if (!reset) evt_cnt <= 2'd0;
    else if (press_pulse) evt_cnt <= evt_cnt + 2'd1;
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input bit b);
    @(negedge clk);
    #1 btn_in = b;
  endtask

  task automatic hold(input bit b, input int n);
    for (int i = 0; i < n; i++) cyc(b);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (n) @(negedge clk);
    #1 reset = 1'b1;
  endtask

  // Called right after an input change; lat = edges from first sample to pulse.
  task automatic wait_pulse(input bit rel, output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (lat < 0 && (rel ? release_pulse : press_pulse)) lat = i;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, p0, r0;
    int exp_seq[5];
    exp_seq = '{1, 2, 3, 0, 1};
    reset = 1'b0;
    btn_in = 1'b0;

    // reset held for two cycles with the button idle
    repeat (2) begin
      @(negedge clk);
      check("rst_state", int'(dbg_state), 0);
      check("rst_out", int'({btn_level, press_pulse, release_pulse}), 0);
    end
    #1 reset = 1'b1;
    hold(1'b0, 4);
    check("post_rst_out", int'({btn_level, press_pulse, release_pulse}), 0);

    // clean press
    p0 = press_seen; r0 = release_seen;
    cyc(1'b1);
    wait_pulse(1'b0, lat);
    check("press_latency", lat, 6);
    check("press_level", int'(btn_level), 1);
    check("press_count", press_seen - p0, 1);
    check("press_no_release", release_seen - r0, 0);

    // clean release
    p0 = press_seen; r0 = release_seen;
    cyc(1'b0);
    wait_pulse(1'b1, lat);
    check("release_latency", lat, 6);
    check("release_level", int'(btn_level), 0);
    check("release_count", release_seen - r0, 1);
    check("release_no_press", press_seen - p0, 0);

    // bounce 1,0,1,1,0 then quiet
    p0 = press_seen; r0 = release_seen;
    cyc(1'b1); cyc(1'b0); cyc(1'b1); cyc(1'b1); cyc(1'b0);
    hold(1'b0, 10);
    check("bounce_level", int'(btn_level), 0);
    check("bounce_pulses", (press_seen - p0) + (release_seen - r0), 0);

    // reset mid-qualification (cnt=2), button kept high through reset
    p0 = press_seen;
    cyc(1'b1);
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    #1 check("abort_out", int'({btn_level, press_pulse, release_pulse}), 0);
    check("abort_state", int'(dbg_state), 0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    wait_pulse(1'b0, lat);
    check("requal_latency", lat, 6);
    check("requal_count", press_seen - p0, 1);
    hold(1'b0, 12);

    // five presses into the downstream counter
    do_reset(2);
    for (int i = 0; i < 5; i++) begin
      p0 = press_seen;
      hold(1'b1, 10);
      check("cnt_value", int'(evt_cnt), exp_seq[i]);
      check("cnt_one_per_press", press_seen - p0, 1);
      hold(1'b0, 10);
    end

    // random bounce runs with occasional reset pulses
    for (int r = 0; r < 400; r++) begin
      if ($urandom_range(0, 24) == 0) begin
        do_reset($urandom_range(1, 2));
      end else begin
        hold(1'(($urandom_range(0, 1))), $urandom_range(1, 2 * DEB + 2));
      end
    end
    hold(1'b0, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/button_debounce_pulse.md
BUTTON_DEBOUNCE_PULSE -- requirements
Module: button_debounce_pulse

Interface
REQ-001 The block SHALL have one parameter: DEBOUNCE_CYCLES, default 4, number of consecutive synchronized samples a new level needs before it is accepted (legal range 2..255).
REQ-002 The port clk SHALL be an input, 1 bit wide: the single clock, with all state updated on its rising edge.
REQ-003 The port reset SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-004 The port btn_in SHALL be an input, 1 bit wide: raw, asynchronous, bouncing pushbutton level, where 1 means pressed.
REQ-005 The port btn_level SHALL be an output, 1 bit wide: registered debounced button level.
REQ-006 The port press_pulse SHALL be an output, 1 bit wide: registered single-cycle pulse on an accepted press, used as the count enable for the downstream counter.
REQ-007 The port release_pulse SHALL be an output, 1 bit wide: registered single-cycle pulse on an accepted release.

Function
REQ-008 btn_in SHALL pass through a 2-flop synchronizer (s1 <= btn_in; btn_sync <= s1), and only btn_sync SHALL feed the FSM.
REQ-009 The FSM SHALL have exactly four states: IDLE (level 0, stable), PRESS_WAIT (qualifying 1), PRESSED (level 1, stable), RELEASE_WAIT (qualifying 0).
REQ-010 The stability counter SHALL be ceil(log2(DEBOUNCE_CYCLES+1)) bits wide and SHALL never wrap; it holds only values 0..DEBOUNCE_CYCLES-1.
REQ-011 In IDLE with btn_sync=1, the FSM SHALL move to PRESS_WAIT with cnt=1; with btn_sync=0 it SHALL stay in IDLE with cnt=0.
REQ-012 In PRESS_WAIT with btn_sync=0, the FSM SHALL return to IDLE with cnt=0 and no pulse (bounce rejected).
REQ-013 In PRESS_WAIT with btn_sync=1 and cnt<DEBOUNCE_CYCLES-1, cnt SHALL increment.
REQ-014 In PRESS_WAIT with btn_sync=1 and cnt=DEBOUNCE_CYCLES-1, the FSM SHALL move to PRESSED with cnt=0, btn_level<=1 and press_pulse<=1.
REQ-015 PRESSED and RELEASE_WAIT SHALL mirror REQ-011..014 with btn_sync polarity inverted; the accepting edge SHALL move the FSM to IDLE with btn_level<=0 and release_pulse<=1.
REQ-016 press_pulse and release_pulse SHALL each be high for exactly one clk cycle per accepted transition and SHALL never be high together.
REQ-017 Latency SHALL be fixed: if btn_in is first sampled high at edge k and then held, btn_level and press_pulse SHALL rise after edge k+1+DEBOUNCE_CYCLES (6 edges for the default).
REQ-018 Any glitch shorter than DEBOUNCE_CYCLES synchronized samples SHALL produce no output change.
REQ-019 btn_level SHALL change only on an accepting edge and SHALL never toggle inside PRESS_WAIT or RELEASE_WAIT.
REQ-020 A held button SHALL produce exactly one press_pulse, with no auto-repeat.

Reset
REQ-021 While reset=0, s1, btn_sync, cnt, btn_level, press_pulse and release_pulse SHALL be 0 and the state SHALL be IDLE, independent of clk.
REQ-022 Reset asserted mid-qualification or while PRESSED SHALL abort immediately with no pulse emitted.
REQ-023 After reset deasserts with btn_in already 1, a full qualification SHALL run and one press_pulse SHALL be emitted.

Verification
REQ-024 Scenario: reset=0 for 2 cycles, btn_in=0 -> all outputs 0 during reset and after release.
REQ-025 Scenario: clean press, btn_in 0->1 held 10 cycles, DEBOUNCE_CYCLES=4 -> btn_level=1 and press_pulse=1 for one cycle, 6 edges after the first high sample; release_pulse stays 0.
REQ-026 Scenario: bounce pattern 1,0,1,1,0 (one cycle each) then 0 -> btn_level stays 0 and no pulses.
REQ-027 Scenario: from PRESSED, btn_in=0 held 10 cycles -> btn_level=0 and one release_pulse 6 edges after the first low sample.
REQ-028 Scenario: reset pulsed low while in PRESS_WAIT with cnt=2 -> outputs 0 immediately; a subsequent held press needs the full 6-edge latency.
REQ-029 Scenario: press_pulse drives the 2-bit up-counter, with 5 separate clean presses -> counter sequence 01,10,11,00,01 and exactly one increment per press.
